// File: rtl/mac_job_sequencer_pkg.sv
// Shared types and constants for the MAC job sequencer: FSM states, handshake
// phases, operand layout within a term and the default MAC timeout.
package mac_job_sequencer_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CLR,
        RD_A,
        LD_A,
        RD_B,
        LD_B,
        RD_C,
        LD_C,
        WAIT_LO,
        WAIT_HI,
        SETTLE,
        STORE,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_LO,
        HS_HI
    } hs_phase_e;

    // Each term is three consecutive words: A, B, C.
    localparam int OFS_A       = 0;
    localparam int OFS_B       = 1;
    localparam int OFS_C       = 2;
    localparam int TERM_STRIDE = 3;

    localparam int DEFAULT_MAC_TIMEOUT = 63;

endpackage

// File: rtl/mac_job_sequencer_if.sv
// Matrix RAM bus plus MAC datapath strobes shared by the sequencer (master)
// and the RAM/datapath side (slave).
interface mac_job_sequencer_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd;
    logic [15:0]       ram_rdata;
    logic              ram_wr;
    logic [15:0]       ram_wdata;
    logic              lda;
    logic              ldb;
    logic              ldc;
    logic              clear_acc;
    logic              macflag;
    logic [15:0]       acc_hi;

    modport master (
        output ram_addr, ram_rd, ram_wr, ram_wdata,
        output lda, ldb, ldc, clear_acc,
        input  ram_rdata, macflag, acc_hi
    );

    modport slave (
        input  ram_addr, ram_rd, ram_wr, ram_wdata,
        input  lda, ldb, ldc, clear_acc,
        output ram_rdata, macflag, acc_hi
    );
endinterface

// File: rtl/mac_job_sequencer_mac_handshake.sv
// Tracks the two MAC handshake phases (macflag falls, then rises) after a go
// pulse, with a per-phase timeout counter that restarts on each phase entry.
module mac_handshake
    import mac_job_sequencer_pkg::*;
#(
    parameter int MAC_TIMEOUT = DEFAULT_MAC_TIMEOUT
) (
    input  logic clk_12,
    input  logic reset_n,
    input  logic go,
    input  logic macflag,
    output logic lo_seen,
    output logic ok,
    output logic timeout
);

    localparam int TW = (MAC_TIMEOUT > 1) ? $clog2(MAC_TIMEOUT + 1) : 1;

    hs_phase_e     phase;
    logic [TW-1:0] timer;

    // Progress wins over a timeout landing in the same cycle.
    assign lo_seen = (phase == HS_LO) && !macflag;
    assign ok      = (phase == HS_HI) && macflag;
    assign timeout = (phase != HS_IDLE) && !lo_seen && !ok &&
                     (timer == TW'(MAC_TIMEOUT));

    // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
    always_ff @(posedge clk_12 or negedge reset_n) begin
        if (!reset_n) begin
            phase <= HS_IDLE;
            timer <= '0;
        end else if (go) begin
            phase <= HS_LO;
            timer <= '0;
        end else if (lo_seen) begin
            phase <= HS_HI;
            timer <= '0;
        end else if (ok || timeout) begin
            phase <= HS_IDLE;
            timer <= '0;
        end else if (phase != HS_IDLE) begin
            timer <= timer + TW'(1);
        end
    end

endmodule

// File: rtl/mac_job_sequencer.sv
// Walks a job of N A/B/C operand triples through the MAC datapath and writes
// the high accumulator word after the last term. All outputs are registered.
module mac_job_sequencer
    import mac_job_sequencer_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int CNT_W       = 8,
    parameter int MAC_TIMEOUT = DEFAULT_MAC_TIMEOUT
) (
    input  logic                clk_12,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [CNT_W-1:0]    term_count,
    output logic                busy,
    output logic                done,
    output logic                error,
    mac_job_sequencer_if.master bus
);

    state_e            state;
    logic [ADDR_W-1:0] ptr;
    logic [CNT_W-1:0]  remaining;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd;
    logic              ram_wr;
    logic [15:0]       ram_wdata;
    logic              lda;
    logic              ldb;
    logic              ldc;
    logic              clear_acc;

    logic hs_go;
    logic hs_lo_seen;
    logic hs_ok;
    logic hs_timeout;

    assign bus.ram_addr  = ram_addr;
    assign bus.ram_rd    = ram_rd;
    assign bus.ram_wr    = ram_wr;
    assign bus.ram_wdata = ram_wdata;
    assign bus.lda       = lda;
    assign bus.ldb       = ldb;
    assign bus.ldc       = ldc;
    assign bus.clear_acc = clear_acc;

    // The handshake is armed on the same edge that moves LD_C into WAIT_LO.
    assign hs_go = (state == LD_C);

    mac_handshake #(
        .MAC_TIMEOUT (MAC_TIMEOUT)
    ) u_handshake (
        .clk_12  (clk_12),
        .reset_n (reset_n),
        .go      (hs_go),
        .macflag (bus.macflag),
        .lo_seen (hs_lo_seen),
        .ok      (hs_ok),
        .timeout (hs_timeout)
    );

    // ptr holds the base of the current term; it advances by one stride when
    // the C read is issued, so after the last term it points at the result slot.
    always_ff @(posedge clk_12 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            ram_addr  <= '0;
            ram_rd    <= 1'b0;
            ram_wr    <= 1'b0;
            ram_wdata <= '0;
            lda       <= 1'b0;
            ldb       <= 1'b0;
            ldc       <= 1'b0;
            clear_acc <= 1'b0;
        end else begin
            // NOTE: strobes default low every cycle; each branch raises only those of the state it enters.
            done      <= 1'b0;
            ram_rd    <= 1'b0;
            ram_wr    <= 1'b0;
            lda       <= 1'b0;
            ldb       <= 1'b0;
            ldc       <= 1'b0;
            clear_acc <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        ptr       <= base_addr;
                        remaining <= term_count;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                        clear_acc <= 1'b1;
                        state     <= CLR;
                    end
                end
                CLR: begin
                    if (remaining == '0) begin
                        // The accumulator was cleared on this edge, so the stored word is zero.
                        ram_addr  <= ptr;
                        ram_wr    <= 1'b1;
                        ram_wdata <= '0;
                        state     <= STORE;
                    end else begin
                        ram_addr <= ptr + ADDR_W'(OFS_A);
                        ram_rd   <= 1'b1;
                        state    <= RD_A;
                    end
                end
                RD_A: begin
                    lda   <= 1'b1;
                    state <= LD_A;
                end
                LD_A: begin
                    ram_addr <= ptr + ADDR_W'(OFS_B);
                    ram_rd   <= 1'b1;
                    state    <= RD_B;
                end
                RD_B: begin
                    ldb   <= 1'b1;
                    state <= LD_B;
                end
                LD_B: begin
                    ram_addr <= ptr + ADDR_W'(OFS_C);
                    ram_rd   <= 1'b1;
                    ptr      <= ptr + ADDR_W'(TERM_STRIDE);
                    state    <= RD_C;
                end
                RD_C: begin
                    ldc   <= 1'b1;
                    state <= LD_C;
                end
                LD_C: begin
                    state <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (hs_timeout) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (hs_lo_seen) begin
                        state <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (hs_timeout) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (hs_ok) begin
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    remaining <= remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        ram_addr  <= ptr;
                        ram_wr    <= 1'b1;
                        ram_wdata <= bus.acc_hi;
                        state     <= STORE;
                    end else begin
                        ram_addr <= ptr + ADDR_W'(OFS_A);
                        ram_rd   <= 1'b1;
                        state    <= RD_A;
                    end
                end
                STORE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Directed bench for mac_job_sequencer with a RAM + 32-cycle MAC model and a
// scoreboard of expected read addresses and result writes.
module tb_mac_job_sequencer;

    localparam int ADDR_W      = 12;
    localparam int CNT_W       = 8;
    localparam int MAC_TIMEOUT = 63;

    logic              clk_12     = 1'b0;
    logic              reset_n    = 1'b0;
    logic              start      = 1'b0;
    logic [ADDR_W-1:0] base_addr  = '0;
    logic [CNT_W-1:0]  term_count = '0;
    logic              busy;
    logic              done;
    logic              error;

    mac_job_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    mac_job_sequencer #(
        .ADDR_W      (ADDR_W),
        .CNT_W       (CNT_W),
        .MAC_TIMEOUT (MAC_TIMEOUT)
    ) dut (
        .clk_12     (clk_12),
        .reset_n    (reset_n),
        .start      (start),
        .base_addr  (base_addr),
        .term_count (term_count),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .bus        (bus)
    );

    always #5 clk_12 = ~clk_12;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int t0    = 0;

    always @(posedge clk_12) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // RAM and datapath model: rdata one cycle after ram_rd; macflag drops the
    // cycle after ldc and rises 32 cycles later with acc += (A*B << 16) + C.
    logic [15:0] mem [0:(1<<ADDR_W)-1];
    logic [15:0] rdata   = '0;
    logic [15:0] op_a    = '0;
    logic [15:0] op_b    = '0;
    logic [15:0] op_c    = '0;
    logic [31:0] acc     = '0;
    logic        macflag = 1'b1;
    int          mac_cnt = 0;
    bit          mac_stuck = 1'b0;

    assign bus.ram_rdata = rdata;
    assign bus.macflag   = macflag;
    assign bus.acc_hi    = acc[31:16];

    always @(posedge clk_12) begin
        if (bus.ram_rd) rdata <= mem[bus.ram_addr];
        if (bus.ram_wr) mem[bus.ram_addr] <= bus.ram_wdata;
        if (bus.clear_acc) acc <= '0;
        if (bus.lda) op_a <= bus.ram_rdata;
        if (bus.ldb) op_b <= bus.ram_rdata;
        if (bus.ldc) begin
            op_c <= bus.ram_rdata;
            if (!mac_stuck) begin
                macflag <= 1'b0;
                mac_cnt <= 32;
            end
        end else if (mac_cnt == 1) begin
            macflag <= 1'b1;
            mac_cnt <= 0;
            acc     <= acc + ((32'(op_a) * 32'(op_b)) << 16) + 32'(op_c);
        end else if (mac_cnt > 1) begin
            mac_cnt <= mac_cnt - 1;
        end
    end

    // Scoreboard queues and per-job event statistics.
    logic [ADDR_W-1:0] rd_q[$];
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [15:0]       wr_data_q[$];
    int ldc_t[$];
    int lda_n, ldb_n, ldc_n, clr_n, done_n, wr_n, bad_rd, bad_wr;
    int clr_rel, first_rd_rel, wr_rel;
    int ld_b2b  = 0;
    int rw_both = 0;
    logic prev_ld = 1'b0;

    always @(negedge clk_12) begin
        prev_ld <= bus.lda | bus.ldb | bus.ldc;
        if ((bus.lda | bus.ldb | bus.ldc) && prev_ld) ld_b2b <= ld_b2b + 1;
        if (bus.ram_rd && bus.ram_wr) rw_both <= rw_both + 1;
        if (bus.lda) lda_n <= lda_n + 1;
        if (bus.ldb) ldb_n <= ldb_n + 1;
        if (bus.ldc) begin
            ldc_n <= ldc_n + 1;
            ldc_t.push_back(cyc - t0);
        end
        if (bus.clear_acc) begin
            clr_n   <= clr_n + 1;
            clr_rel <= cyc - t0;
        end
        if (done) done_n <= done_n + 1;
        if (bus.ram_rd) begin
            if (first_rd_rel < 0) first_rd_rel <= cyc - t0;
            if (rd_q.size() == 0) bad_rd <= bad_rd + 1;
            else check("rd_addr", bus.ram_addr, rd_q.pop_front());
        end
        if (bus.ram_wr) begin
            wr_n   <= wr_n + 1;
            wr_rel <= cyc - t0;
            if (wr_addr_q.size() == 0) bad_wr <= bad_wr + 1;
            else begin
                check("wr_addr", bus.ram_addr, wr_addr_q.pop_front());
                check("wr_data", bus.ram_wdata, wr_data_q.pop_front());
            end
        end
    end

    task automatic clear_stats();
        lda_n = 0; ldb_n = 0; ldc_n = 0; clr_n = 0; done_n = 0; wr_n = 0;
        bad_rd = 0; bad_wr = 0;
        clr_rel = -1; first_rd_rel = -1; wr_rel = -1;
        ldc_t.delete();
    endtask

    // Loads N terms (A=3+i, B=1+i, C=5+i) and queues the expected traffic.
    task automatic prep(input logic [ADDR_W-1:0] base, input int n, input bit expect_wr);
        logic [ADDR_W-1:0] a;
        logic [31:0]       e;
        logic [15:0]       va, vb, vc;
        a = base;
        e = '0;
        for (int i = 0; i < n; i++) begin
            va = 16'(3 + i);
            vb = 16'(1 + i);
            vc = 16'(5 + i);
            mem[a] = va; rd_q.push_back(a); a = a + 1'b1;
            mem[a] = vb; rd_q.push_back(a); a = a + 1'b1;
            mem[a] = vc; rd_q.push_back(a); a = a + 1'b1;
            e = e + ((32'(va) * 32'(vb)) << 16) + 32'(vc);
        end
        if (expect_wr) begin
            wr_addr_q.push_back(a);
            wr_data_q.push_back(e[31:16]);
        end
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] base, input int n);
        @(negedge clk_12);
        base_addr  = base;
        term_count = CNT_W'(n);
        start      = 1'b1;
        t0         = cyc;
        @(negedge clk_12);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int rel);
        int k;
        k   = 0;
        rel = -1;
        while (k < limit && rel < 0) begin
            @(negedge clk_12);
            k++;
            if (done) rel = cyc - t0;
        end
    endtask

    task automatic job_end(input string tag, input int n_ld, input int exp_first_rd,
                           input int exp_wr_n, input int exp_wr_rel);
        @(negedge clk_12);
        check({tag, "_lda_n"}, lda_n, n_ld);
        check({tag, "_ldb_n"}, ldb_n, n_ld);
        check({tag, "_ldc_n"}, ldc_n, n_ld);
        check({tag, "_clr_n"}, clr_n, 1);
        check({tag, "_clr_rel"}, clr_rel, 1);
        check({tag, "_first_rd"}, first_rd_rel, exp_first_rd);
        check({tag, "_wr_n"}, wr_n, exp_wr_n);
        if (exp_wr_n > 0) check({tag, "_wr_rel"}, wr_rel, exp_wr_rel);
        check({tag, "_rd_left"}, rd_q.size(), 0);
        check({tag, "_wr_left"}, wr_addr_q.size(), 0);
        check({tag, "_bad_rd"}, bad_rd, 0);
        check({tag, "_bad_wr"}, bad_wr, 0);
        check({tag, "_done_n"}, done_n, 1);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    int drel;

    initial begin
        clear_stats();
        repeat (3) @(negedge clk_12);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_ram_rd", bus.ram_rd, 0);
        check("rst_ram_wr", bus.ram_wr, 0);
        check("rst_ram_addr", bus.ram_addr, 0);
        check("rst_ram_wdata", bus.ram_wdata, 0);
        check("rst_strobes", {bus.lda, bus.ldb, bus.ldc, bus.clear_acc}, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_12);

        // N=1 at 0x100: A=3, B=1, C=5
        clear_stats();
        prep(12'h100, 1, 1'b1);
        pulse_start(12'h100, 1);
        check("n1_busy", busy, 1);
        wait_done(200, drel);
        check("n1_done_rel", drel, 43);
        job_end("n1", 1, 2, 1, 42);

        // N=3 at 0x010
        clear_stats();
        prep(12'h010, 3, 1'b1);
        pulse_start(12'h010, 3);
        wait_done(400, drel);
        check("n3_done_rel", drel, 123);
        job_end("n3", 3, 2, 1, 122);
        check("n3_ldc_t_n", ldc_t.size(), 3);
        if (ldc_t.size() == 3) begin
            check("n3_ldc_gap1", (ldc_t[1] - ldc_t[0]) >= 40, 1);
            check("n3_ldc_gap2", (ldc_t[2] - ldc_t[1]) >= 40, 1);
        end

        // N=0 at 0x200
        clear_stats();
        prep(12'h200, 0, 1'b1);
        pulse_start(12'h200, 0);
        wait_done(50, drel);
        check("n0_done_rel", drel, 3);
        job_end("n0", 0, -1, 1, 2);

        // Address wrap: base 0xFFE
        clear_stats();
        prep(12'hFFE, 1, 1'b1);
        pulse_start(12'hFFE, 1);
        wait_done(200, drel);
        check("wrap_done_rel", drel, 43);
        job_end("wrap", 1, 2, 1, 42);

        // MAC never drops macflag: timeout in WAIT_LO
        mac_stuck = 1'b1;
        clear_stats();
        prep(12'h300, 1, 1'b0);
        pulse_start(12'h300, 1);
        wait_done(300, drel);
        check("to_done_rel", drel, 72);
        check("to_error_at_done", error, 1);
        job_end("to", 1, 2, 0, 0);
        check("to_error_sticky", error, 1);
        mac_stuck = 1'b0;

        // Next start clears the sticky error
        clear_stats();
        prep(12'h050, 0, 1'b1);
        pulse_start(12'h050, 0);
        check("clr_error", error, 0);
        wait_done(50, drel);
        check("clr_done_rel", drel, 3);
        job_end("clr", 0, -1, 1, 2);

        // start while busy is ignored
        clear_stats();
        prep(12'h100, 1, 1'b1);
        pulse_start(12'h100, 1);
        repeat (9) @(negedge clk_12);
        base_addr  = 12'h400;
        term_count = 8'd5;
        start      = 1'b1;
        @(negedge clk_12);
        start = 1'b0;
        wait_done(200, drel);
        check("ign_done_rel", drel, 43);
        job_end("ign", 1, 2, 1, 42);
        repeat (5) @(negedge clk_12);
        check("ign_no_restart", busy, 0);
        check("ign_done_once", done_n, 1);

        // Reset in WAIT_HI aborts the job with no write and no done
        clear_stats();
        prep(12'h100, 1, 1'b0);
        pulse_start(12'h100, 1);
        repeat (19) @(negedge clk_12);
        check("ar_busy_before", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        check("ar_busy", busy, 0);
        check("ar_ram_addr", bus.ram_addr, 0);
        check("ar_ram_wdata", bus.ram_wdata, 0);
        check("ar_rd_wr", {bus.ram_rd, bus.ram_wr}, 0);
        check("ar_strobes", {bus.lda, bus.ldb, bus.ldc, bus.clear_acc}, 0);
        check("ar_done_error", {done, error}, 0);
        @(negedge clk_12);
        reset_n = 1'b1;
        repeat (80) @(negedge clk_12);
        check("ar_wr_n", wr_n, 0);
        check("ar_bad_wr", bad_wr, 0);
        check("ar_done_n", done_n, 0);
        check("ar_busy_after", busy, 0);
        check("ar_rd_left", rd_q.size(), 0);

        check("ld_back_to_back", ld_b2b, 0);
        check("rd_wr_overlap", rw_both, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mac_job_sequencer.md
# mac_job_sequencer

Autonomous sequencer for the matrix multiply-accumulate datapath. Given a base address and a term count in matrix bus RAM, it clears the accumulator, then for each term fetches the A, B and C operands, pulses the datapath load strobes, and waits for the 32-cycle MAC to finish. After the last term it writes the high accumulator word back to RAM. It sits between the CPU-facing matrix controller (job start) and the MAC datapath (operand registers and accumulator).

## Interface
Parameters:
- ADDR_W, 12: matrix RAM address width.
- CNT_W, 8: term-count width.
- MAC_TIMEOUT, 63: maximum cycles spent waiting in either MAC handshake phase before abort.

Ports:
- clk_12  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  job request; sampled only in IDLE.
- base_addr  in  ADDR_W  first operand address of the job.
- term_count  in  CNT_W  number of terms N.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky MAC-timeout flag; cleared when the next start is accepted.
- ram_addr  out  ADDR_W  RAM address.
- ram_rd  out  1  read strobe; ram_rdata is valid exactly one cycle later.
- ram_rdata  in  16  RAM read data.
- ram_wr  out  1  write strobe.
- ram_wdata  out  16  write data.
- lda, ldb, ldc  out  1  one-cycle operand load strobes. The datapath samples ram_rdata on the same edge.
- clear_acc  out  1  one-cycle accumulator clear.
- macflag  in  1  datapath MAC idle flag (1 = idle).
- acc_hi  in  16  accumulator bits [31:16].

## Operation
- States:
  - IDLE
  - CLR
  - RD_A, LD_A
  - RD_B, LD_B
  - RD_C, LD_C
  - WAIT_LO
  - WAIT_HI
  - SETTLE
  - STORE
  - DONE
- IDLE: on start=1, latch base_addr into ptr, latch term_count into remaining, clear error, go to CLR.
- CLR: assert clear_acc. If remaining==0, go to STORE; otherwise go to RD_A.
- RD_x: drive ram_addr=ptr and ram_rd=1, increment ptr, go to LD_x.
- LD_x: assert ld_x, go to the next RD state. LD_C instead goes to WAIT_LO with the timer cleared.
- Memory layout: term i occupies base+3i (A), base+3i+1 (B), base+3i+2 (C). The result is written to base+3N.
- ptr arithmetic is modulo 2^ADDR_W; wrap past the top of RAM is legal and silent.
- WAIT_LO: wait for macflag==0. WAIT_HI: wait for macflag==1. The timer restarts on entry to each wait state.
- SETTLE: one cycle, which lets the accumulate edge land. Then decrement remaining: if the new value is 0, go to STORE; otherwise go to RD_A.
- STORE: ram_addr=ptr, ram_wr=1, ram_wdata=acc_hi. Go to DONE.
- DONE: done=1, go to IDLE.
- Timeout: if the timer reaches MAC_TIMEOUT in either wait state, set error, skip STORE, and go to DONE. done still pulses.
- start while busy is ignored and not queued.
- ld strobes are never asserted on consecutive cycles, so ldc always presents a clean rising edge to the datapath.
- Exactly one of ram_rd/ram_wr may be high in a cycle; both are never high together.

## Timing
- Reset values: busy=0, done=0, error=0, ram_rd=0, ram_wr=0, ram_addr=0, ram_wdata=0, lda=ldb=ldc=0, clear_acc=0. State=IDLE. ptr/remaining=0.
- Reset asserted mid-job aborts immediately. No write and no done are produced.
- All outputs are registered.
- start sampled at edge 0 gives clear_acc high in cycle 1 and the first ram_rd in cycle 2.
- Per term: 6 cycles (RD/LD x3), plus the handshake time, plus 1 SETTLE cycle. With the standard datapath (macflag low 1 cycle after ldc, high 32 cycles later) a term is 40 cycles.
- N=0: the write occurs in cycle 2 with ram_addr=base and ram_wdata=acc_hi (0 after clear). done pulses in cycle 3.

## Structure
- The shared package holds:
  - the state enum;
  - operand offset constants OFS_A=0, OFS_B=1, OFS_C=2 and TERM_STRIDE=3;
  - the default MAC_TIMEOUT.
- One sub-module, mac_handshake: encapsulates the WAIT_LO/WAIT_HI phases and the timeout counter. It takes a go pulse and returns ok or timeout pulses.

## Test plan
- N=1, base=0x100, RAM A=3, B=1, C=5, standard MAC model: reads at 0x100, 0x101, 0x102. lda/ldb/ldc each pulse once. Write to 0x103 with acc_hi from the model. done at cycle 2+40+1.
- N=3, base=0x010: 9 reads at 0x010..0x018 in order, 3 ldc pulses each ≥40 cycles apart, 1 clear_acc, write at 0x019.
- N=0, base=0x200: clear_acc in cycle 1, write 0x0000 to 0x200 in cycle 2, done in cycle 3, no lda/ldb/ldc.
- base=0xFFE, N=1: reads at 0xFFE, 0xFFF, 0x000. Write at 0x001.
- MAC model holds macflag=1 forever after ldc: error=1 after 63 wait cycles, no ram_wr, done pulses. A subsequent start clears error.
- start pulsed again mid-job: ignored. reset_n low during WAIT_HI: all outputs 0 immediately. After release, no write, done stays 0.
